// File: rtl/tv_pkg.sv
// Shared types and vector-word layout helpers for the test-vector sequencer.
// A vector word is {valid, inputs, expected} with expected in the low bits.
package tv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StSettle,
    StCheck,
    StDone
  } tv_state_e;

  localparam int unsigned SettleCntW = 4;

  function automatic int unsigned tv_word_w(input int unsigned in_w, input int unsigned out_w);
    return 1 + in_w + out_w;
  endfunction

  function automatic int unsigned tv_valid_pos(input int unsigned in_w, input int unsigned out_w);
    return in_w + out_w;
  endfunction

  function automatic int unsigned tv_in_lsb(input int unsigned out_w);
    return out_w;
  endfunction

  function automatic int unsigned tv_exp_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/tv_sequencer.sv
// Walks a vector memory, drives a combinational DUT, waits SETTLE cycles and
// checks its response, counting vectors and mismatches until a marker or wrap.
module tv_sequencer
  import tv_pkg::*;
#(
  parameter int unsigned IN_W   = 3,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic [ADDR_W-1:0]                   mem_addr,
  input  logic [tv_word_w(IN_W, OUT_W)-1:0]   mem_rdata,
  output logic [IN_W-1:0]                     dut_in,
  input  logic [OUT_W-1:0]                    dut_out,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [ADDR_W:0]                     vec_count,
  output logic [ADDR_W:0]                     err_count,
  output logic                                err_valid,
  output logic [ADDR_W-1:0]                   err_addr,
  output logic [OUT_W-1:0]                    err_got,
  output logic [OUT_W-1:0]                    err_exp
);

  localparam int unsigned ValidPos = tv_valid_pos(IN_W, OUT_W);
  localparam int unsigned InLsb    = tv_in_lsb(OUT_W);
  localparam int unsigned ExpLsb   = tv_exp_lsb();

  localparam logic [SettleCntW-1:0] SettleInit = SettleCntW'(SETTLE - 1);
  localparam logic [SettleCntW-1:0] SettleOne  = SettleCntW'(1);
  localparam logic [ADDR_W:0]       CntOne     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0]     AddrOne    = ADDR_W'(1);

  tv_state_e state_q, state_d;

  logic [ADDR_W-1:0]     addr_q;
  logic [OUT_W-1:0]      exp_q;
  logic [SettleCntW-1:0] settle_q;

  logic clear_run, load_vec, do_check, mismatch, word_valid, addr_last;

  assign word_valid = mem_rdata[ValidPos];
  assign addr_last  = &addr_q;
  assign mismatch   = (dut_out != exp_q);

  assign mem_addr = addr_q;
  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clear_run = 1'b0;
    load_vec  = 1'b0;
    do_check  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          clear_run = 1'b1;
          state_d   = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        // An invalid word is the end marker and is never checked.
        if (word_valid) begin
          load_vec = 1'b1;
          state_d  = StSettle;
        end else begin
          state_d = StDone;
        end
      end
      StSettle: begin
        if (settle_q == '0) state_d = StCheck;
      end
      StCheck: begin
        do_check = 1'b1;
        state_d  = addr_last ? StDone : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      exp_q     <= '0;
      settle_q  <= '0;
      dut_in    <= '0;
      vec_count <= '0;
      err_count <= '0;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_got   <= '0;
      err_exp   <= '0;
    end else begin
      err_valid <= do_check && mismatch;

      if (clear_run) begin
        addr_q    <= '0;
        vec_count <= '0;
        err_count <= '0;
        err_addr  <= '0;
        err_got   <= '0;
        err_exp   <= '0;
      end

      if (load_vec) begin
        dut_in   <= mem_rdata[InLsb +: IN_W];
        exp_q    <= mem_rdata[ExpLsb +: OUT_W];
        settle_q <= SettleInit;
      end else if ((state_q == StSettle) && (settle_q != '0)) begin
        settle_q <= settle_q - SettleOne;
      end

      if (do_check) begin
        vec_count <= vec_count + CntOne;
        if (mismatch) begin
          err_count <= err_count + CntOne;
          err_addr  <= addr_q;
          err_got   <= dut_out;
          err_exp   <= exp_q;
        end
        // Address holds at all-ones when memory is exhausted.
        if (!addr_last) addr_q <= addr_q + AddrOne;
      end
    end
  end

endmodule

// File: tb/tb_tv_sequencer.sv
// Self-checking bench for tv_sequencer: table-driven runs, randomized runs
// against a reference model, reset/restart, settle timing and address wrap.
module tb_tv_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start_x;

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  function automatic logic silly(input logic [2:0] x);
    return (~x[1] & ~x[0]) | (x[2] & ~x[1]);
  endfunction

  // Main instance: defaults (IN_W=3, OUT_W=1, ADDR_W=8, SETTLE=1)
  logic [7:0] mem_addr;
  logic [4:0] rdata;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass, err_valid;
  logic [8:0] vec_count, err_count;
  logic [7:0] err_addr;
  logic       err_got, err_exp;
  logic [4:0] mem0 [256];

  assign dut_out = silly(dut_in);
  always @(posedge clk) rdata <= mem0[mem_addr];

  int pulses = 0;
  always @(posedge clk) if (err_valid) pulses <= pulses + 1;

  tv_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_rdata(rdata),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .err_valid(err_valid),
    .err_addr(err_addr), .err_got(err_got), .err_exp(err_exp)
  );

  // SETTLE=4 instance; its DUT answers wrongly until 4 cycles after dut_in changes.
  logic [7:0] mem_addr_s4;
  logic [4:0] rdata_s4;
  logic [2:0] dut_in_s4;
  logic       dut_out_s4;
  logic       busy_s4, done_s4, pass_s4, err_valid_s4;
  logic [8:0] vec_s4, err_s4;
  logic [7:0] err_addr_s4;
  logic       err_got_s4, err_exp_s4;
  logic [4:0] mem4 [256];
  int         cyc_g = 0;
  int         chg_cyc = 0;
  logic [2:0] prev_s4 = 3'd0;

  always @(posedge clk) cyc_g <= cyc_g + 1;
  always @(negedge clk) begin
    if (dut_in_s4 != prev_s4) chg_cyc <= cyc_g;
    prev_s4 <= dut_in_s4;
  end
  assign dut_out_s4 = ((cyc_g - chg_cyc) >= 4) ? silly(dut_in_s4) : ~silly(dut_in_s4);
  always @(posedge clk) rdata_s4 <= mem4[mem_addr_s4];

  tv_sequencer #(.SETTLE(4)) u_s4 (
    .clk(clk), .reset(reset), .start(start_x), .mem_addr(mem_addr_s4), .mem_rdata(rdata_s4),
    .dut_in(dut_in_s4), .dut_out(dut_out_s4), .busy(busy_s4), .done(done_s4),
    .pass(pass_s4), .vec_count(vec_s4), .err_count(err_s4), .err_valid(err_valid_s4),
    .err_addr(err_addr_s4), .err_got(err_got_s4), .err_exp(err_exp_s4)
  );

  // ADDR_W=3 instance with all 8 words valid: finishes by address exhaustion.
  logic [2:0] mem_addr_a3;
  logic [4:0] rdata_a3;
  logic [2:0] dut_in_a3;
  logic       dut_out_a3;
  logic       busy_a3, done_a3, pass_a3, err_valid_a3;
  logic [3:0] vec_a3, err_a3;
  logic [2:0] err_addr_a3;
  logic       err_got_a3, err_exp_a3;
  logic [4:0] mema [8];

  assign dut_out_a3 = silly(dut_in_a3);
  always @(posedge clk) rdata_a3 <= mema[mem_addr_a3];

  tv_sequencer #(.ADDR_W(3)) u_a3 (
    .clk(clk), .reset(reset), .start(start_x), .mem_addr(mem_addr_a3), .mem_rdata(rdata_a3),
    .dut_in(dut_in_a3), .dut_out(dut_out_a3), .busy(busy_a3), .done(done_a3),
    .pass(pass_a3), .vec_count(vec_a3), .err_count(err_a3), .err_valid(err_valid_a3),
    .err_addr(err_addr_a3), .err_got(err_got_a3), .err_exp(err_exp_a3)
  );

  typedef struct {
    int         n;
    logic [7:0] corrupt;
    int         poke;
    int         exp_vec;
    int         exp_err;
    int         exp_pass;
    int         exp_cyc;
    int         exp_pulses;
    int         exp_eaddr;
    int         exp_got;
    int         exp_eexp;
    int         exp_din;
  } row_t;

  // Fill mem0 with the sillyfunction truth table (inputs = address), flipping
  // the expected bit where corrupt is set, followed by an end marker.
  task automatic load_table(input int n, input logic [7:0] corrupt);
    for (int i = 0; i < n; i++) begin
      mem0[i] = {1'b1, 3'(i), silly(3'(i)) ^ corrupt[i]};
    end
    mem0[n] = {1'b0, 4'($urandom)};
  endtask

  // Starts the main instance and returns start-sample-to-done cycle count.
  task automatic run_main(input string tag, input int poke, output int cyc, output int npulse);
    int p0;
    @(negedge clk);
    p0 = pulses;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    chk({tag, "_cleared_vec"}, vec_count, 0);
    chk({tag, "_cleared_err"}, err_count, 0);
    chk({tag, "_busy"}, busy, 1);
    while (!done && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == poke);
    end
    start = 1'b0;
    chk({tag, "_done_reached"}, done, 1);
    chk({tag, "_busy_low"}, busy, 0);
    npulse = pulses - p0;
  endtask

  row_t rows[5];

  initial begin
    int cyc, np, d4, da, n, errs, la, lg, le;
    logic [2:0] x;
    logic       e;

    reset   = 1'b1;
    start   = 1'b0;
    start_x = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem4[i] = '0;
    end
    for (int i = 0; i < 8; i++) mema[i] = {1'b1, 3'(i), silly(3'(i))};
    for (int i = 0; i < 8; i++) mem4[i] = {1'b1, 3'(i + 1), silly(3'(i + 1))};

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_dut_in", dut_in, 0);
    reset = 1'b0;

    //         n  corrupt       poke vec err pass cyc pul eaddr got eexp din
    rows[0] = '{0, 8'h00,        -1,  0,  0,  1,   3,  0,  0,   0,  0,   0};
    rows[1] = '{8, 8'h00,        -1,  8,  0,  1,  35,  0,  0,   0,  0,   7};
    rows[2] = '{8, 8'b0010_0100, -1,  8,  2,  0,  35,  2,  5,   1,  0,   7};
    rows[3] = '{8, 8'h00,        10,  8,  0,  1,  35,  0,  0,   0,  0,   7};
    rows[4] = '{3, 8'h01,        -1,  3,  1,  0,  15,  1,  0,   1,  0,   2};

    foreach (rows[r]) begin
      string t;
      t = $sformatf("row%0d", r);
      load_table(rows[r].n, rows[r].corrupt);
      run_main(t, rows[r].poke, cyc, np);
      chk({t, "_cycles"}, cyc, rows[r].exp_cyc);
      chk({t, "_vec"}, vec_count, rows[r].exp_vec);
      chk({t, "_err"}, err_count, rows[r].exp_err);
      chk({t, "_pass"}, pass, rows[r].exp_pass);
      chk({t, "_pulses"}, np, rows[r].exp_pulses);
      chk({t, "_err_addr"}, err_addr, rows[r].exp_eaddr);
      chk({t, "_err_got"}, err_got, rows[r].exp_got);
      chk({t, "_err_exp"}, err_exp, rows[r].exp_eexp);
      chk({t, "_dut_in"}, dut_in, rows[r].exp_din);
    end

    // Randomized runs against a plain loop over the memory image.
    for (int it = 0; it < 8; it++) begin
      string t;
      t = $sformatf("rand%0d", it);
      n = $urandom_range(0, 20);
      errs = 0; la = 0; lg = 0; le = 0;
      for (int i = 0; i < n; i++) begin
        x = 3'($urandom);
        e = silly(x) ^ ($urandom_range(0, 3) == 0);
        mem0[i] = {1'b1, x, e};
        if (e != silly(x)) begin
          errs++;
          la = i;
          lg = silly(x);
          le = e;
        end
      end
      mem0[n] = {1'b0, 4'($urandom)};
      run_main(t, -1, cyc, np);
      chk({t, "_cycles"}, cyc, 4 * n + 3);
      chk({t, "_vec"}, vec_count, n);
      chk({t, "_err"}, err_count, errs);
      chk({t, "_pulses"}, np, errs);
      chk({t, "_pass"}, pass, errs == 0);
      chk({t, "_err_addr"}, err_addr, la);
      chk({t, "_err_got"}, err_got, lg);
      chk({t, "_err_exp"}, err_exp, le);
    end

    // Reset during SETTLE of vector 3, then rerun the full table.
    load_table(8, 8'h00);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 15) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("midrun_vec", vec_count, 3);
    chk("midrun_dut_in", dut_in, 3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_vec", vec_count, 0);
    chk("arst_err", err_count, 0);
    chk("arst_dut_in", dut_in, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_err_valid", err_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    run_main("rerun", -1, cyc, np);
    chk("rerun_cycles", cyc, 35);
    chk("rerun_vec", vec_count, 8);
    chk("rerun_pass", pass, 1);

    // SETTLE=4 timing and ADDR_W=3 exhaustion, run side by side.
    @(negedge clk);
    start_x = 1'b1;
    @(posedge clk);
    #1;
    start_x = 1'b0;
    cyc = 1;
    d4 = -1;
    da = -1;
    while ((d4 < 0 || da < 0) && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_s4 && d4 < 0) d4 = cyc;
      if (done_a3 && da < 0) da = cyc;
    end
    chk("s4_done_cycle", d4, 1 + 8 * 7 + 2);
    chk("s4_vec", vec_s4, 8);
    chk("s4_err", err_s4, 0);
    chk("s4_pass", pass_s4, 1);
    chk("a3_done_cycle", da, 1 + 8 * 4);
    chk("a3_vec", vec_a3, 8);
    chk("a3_err", err_a3, 0);
    chk("a3_pass", pass_a3, 1);
    chk("a3_mem_addr", mem_addr_a3, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tv_sequencer.md
# tv_sequencer

Synthesizable test-vector sequencer and checker that replaces a simulation-only testbench loop with hardware. It walks a vector memory from address 0, drives each vector's inputs into a combinational device under test (for example `sillyfunction`), waits a programmable settle time, and compares the DUT output against the expected value. It counts vectors and mismatches, and stops at an end-of-vectors marker. It sits between a vector ROM/RAM and the DUT, and reports status to a host or LEDs.

## Interface
- `IN_W`, default 3: DUT input width.
- `OUT_W`, default 1: DUT output width.
- `ADDR_W`, default 8: vector memory address width.
- `SETTLE`, default 1: cycles between driving `dut_in` and sampling `dut_out`. Legal range is 1..15.

- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin a run; sampled in IDLE or DONE only.
- `mem_addr`  out  ADDR_W: vector memory read address.
- `mem_rdata`  in  1+IN_W+OUT_W: `{valid, inputs, expected}`. Memory has 1-cycle synchronous read.
- `dut_in`  out  IN_W: registered DUT stimulus.
- `dut_out`  in  OUT_W: DUT response.
- `busy`  out  1: high from `start` acceptance until DONE.
- `done`  out  1: level; high in DONE.
- `pass`  out  1: `done && err_count==0`.
- `vec_count`  out  ADDR_W+1: vectors checked.
- `err_count`  out  ADDR_W+1: mismatches.
- `err_valid`  out  1: 1-cycle pulse on each mismatch.
- `err_addr`, `err_got`, `err_exp`  out  ADDR_W / OUT_W / OUT_W: details of the last mismatch. Held until the next mismatch or start.

## Operation
- **States:** IDLE, FETCH, LOAD, SETTLE, CHECK, DONE.
- **IDLE/DONE + start:**
  - Clear `vec_count`, `err_count`, `err_*`, `addr`.
  - Go to FETCH.
  - `start` in any other state is ignored.
- **FETCH:** drive `mem_addr = addr`, then go to LOAD.
- **LOAD:** `mem_rdata` is valid this cycle.
  - If `valid==0`, the end marker is reached: go to DONE with no check.
  - Otherwise register `dut_in <= inputs` and `exp <= expected`, load the settle counter with `SETTLE-1`, and go to SETTLE.
- **SETTLE:** decrement the counter. At 0, go to CHECK.
- **CHECK:** compare `dut_out != exp`.
  - On mismatch: increment `err_count`, pulse `err_valid`, and capture `err_addr=addr`, `err_got`, `err_exp`.
  - Always increment `vec_count`.
  - If `addr` is all-ones, the memory is exhausted: go to DONE. Otherwise `addr++` and go to FETCH.
- **DONE:** hold all results. `dut_in` keeps the last vector.
- **Counter width:** ADDR_W+1 bits, which holds the full 2^ADDR_W count, so counts never wrap.
- **Reset values:** all outputs and counters are 0, `dut_in`=0, state is IDLE. Reset mid-run aborts immediately and leaves no partial results.

## Timing
- Per vector: FETCH 1 + LOAD 1 + SETTLE `SETTLE` + CHECK 1, i.e. `SETTLE+3` cycles.
- `dut_in` changes on the clock edge leaving LOAD. `dut_out` is sampled on the edge leaving CHECK, at least `SETTLE` full cycles later.
- `busy` rises the cycle after `start` is sampled and falls on entry to DONE. `done` rises in the same cycle that `busy` falls.
- `err_valid` and the count updates are visible the cycle after CHECK.
- N valid vectors followed by a marker complete in `1 + N*(SETTLE+3) + 2` cycles from the `start` sample to `done`.
- A run with an empty memory (marker at address 0) completes in 3 cycles with `vec_count=0` and `pass=1`.

## Structure
- **Package `tv_pkg`:**
  - `tv_state_e` enum for the six states.
  - Localparam helpers for the word width `1+IN_W+OUT_W`.
  - Field-offset functions for valid, inputs and expected.
- **Sub-modules:** none. The FSM, settle counter and result registers fit in one module.
- **Vector ROM:** a separate `tv_rom`, instantiated only in the bench and top level, initialised with `$readmemb`.

## Test plan
- **Happy path:** `sillyfunction`, 8 vectors with truth table 000→1, 001→0, 010→0, 011→0, 100→1, 101→1, 110→0, 111→0, then a marker. Required: `vec_count`=8, `err_count`=0, `pass`=1, `done` at cycle 1+8*4+2=35 (SETTLE=1).
- **Injected mismatches:** corrupt the expected values at addresses 2 and 5. Required: 2 `err_valid` pulses, final `err_addr`=5, `err_got`=1, `err_exp`=0, `err_count`=2, `pass`=0.
- **Empty memory:** marker at address 0. Required: `done` after 3 cycles, `vec_count`=0, `pass`=1, `dut_in` stays 0.
- **Reset and restart:** assert `reset` during SETTLE of vector 3. Required: all outputs 0 asynchronously, state IDLE. A following `start` reruns the full table to `pass`=1.
- **Ignored start, then rerun:**
  - Pulse `start` while `busy`: no effect on the counts.
  - Pulse `start` in DONE: counts clear and the run repeats with identical results.
- **Settle and exhaustion:**
  - With SETTLE=4, `dut_out` is sampled exactly 4 cycles after `dut_in` changes.
  - With ADDR_W=3 and all 8 words valid: DONE is reached via address wrap, with `vec_count`=8.
